// File: rtl/axis_rate_monitor.sv
// Passive AXI-Stream throughput monitor: per-channel cumulative byte/beat/packet/active-cycle
// counters plus a shared fixed-length rate window. Never drives or alters the monitored streams.
module axis_rate_monitor #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned WINDOW_CYCLES = 156250,
  parameter int unsigned CNT_WIDTH     = 48,
  parameter int unsigned WIN_WIDTH     = 32
) (
  input  logic                             s_aclk,
  input  logic                             s_areset,
  input  logic                             clear,
  input  logic [NUM_CH-1:0]                mon_tvalid,
  input  logic [NUM_CH-1:0]                mon_tready,
  input  logic [NUM_CH*(DATA_WIDTH/8)-1:0] mon_tkeep,
  input  logic [NUM_CH-1:0]                mon_tlast,
  output logic [NUM_CH*CNT_WIDTH-1:0]      total_bytes,
  output logic [NUM_CH*CNT_WIDTH-1:0]      total_beats,
  output logic [NUM_CH*CNT_WIDTH-1:0]      pkt_count,
  output logic [NUM_CH*CNT_WIDTH-1:0]      active_cycles,
  output logic [NUM_CH*WIN_WIDTH-1:0]      window_bytes,
  output logic                             window_valid,
  output logic [NUM_CH-1:0]                keep_err
);

  localparam int unsigned KW = DATA_WIDTH / 8;
  localparam int unsigned BW = $clog2(KW + 1);
  localparam int unsigned TW = $clog2(WINDOW_CYCLES);
  localparam logic [TW-1:0] TimerLast = TW'(WINDOW_CYCLES - 1);

  // Saturating adds: the carry out of the full-width sum detects overflow for any addend.
  function automatic logic [CNT_WIDTH-1:0] sat_cnt(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [BW-1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + (CNT_WIDTH + 1)'(b);
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  function automatic logic [WIN_WIDTH-1:0] sat_win(input logic [WIN_WIDTH-1:0] a,
                                                   input logic [BW-1:0] b);
    logic [WIN_WIDTH:0] s;
    s = {1'b0, a} + (WIN_WIDTH + 1)'(b);
    return s[WIN_WIDTH] ? '1 : s[WIN_WIDTH-1:0];
  endfunction

  logic [TW-1:0]        r_timer;
  logic                 r_win_valid;
  logic [NUM_CH-1:0]    r_started;
  logic [NUM_CH-1:0]    r_keep_err;
  logic [CNT_WIDTH-1:0] r_total_bytes [NUM_CH];
  logic [CNT_WIDTH-1:0] r_total_beats [NUM_CH];
  logic [CNT_WIDTH-1:0] r_pkt_count   [NUM_CH];
  logic [CNT_WIDTH-1:0] r_active      [NUM_CH];
  logic [WIN_WIDTH-1:0] r_acc         [NUM_CH];
  logic [WIN_WIDTH-1:0] r_win_bytes   [NUM_CH];

  logic [KW-1:0]     w_keep  [NUM_CH];
  logic [BW-1:0]     w_cnt   [NUM_CH];
  logic [BW-1:0]     w_bytes [NUM_CH];
  logic [NUM_CH-1:0] w_hs;
  logic [NUM_CH-1:0] w_keep_bad;
  logic              w_last_cyc;

  assign w_last_cyc = (r_timer == TimerLast);

  always_comb begin
    w_hs       = '0;
    w_keep_bad = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_keep[c] = mon_tkeep[c*KW +: KW];
      w_cnt[c]  = '0;
      for (int i = 0; i < KW; i++) begin
        w_cnt[c] = w_cnt[c] + BW'(w_keep[c][i]);
      end
      w_hs[c]    = mon_tvalid[c] & mon_tready[c];
      w_bytes[c] = w_hs[c] ? w_cnt[c] : '0;
      // Legal keep is 2^n-1, n>=1: nonzero and keep & (keep+1) clears every bit.
      w_keep_bad[c] = w_hs[c] & ((w_keep[c] == '0) |
                                 ((w_keep[c] & (w_keep[c] + KW'(1))) != '0));
    end
  end

  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      r_timer     <= '0;
      r_win_valid <= 1'b0;
      r_started   <= '0;
      r_keep_err  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_total_bytes[c] <= '0;
        r_total_beats[c] <= '0;
        r_pkt_count[c]   <= '0;
        r_active[c]      <= '0;
        r_acc[c]         <= '0;
        r_win_bytes[c]   <= '0;
      end
    end else if (clear) begin
      r_timer     <= '0;
      r_win_valid <= 1'b0;
      r_started   <= '0;
      r_keep_err  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_total_bytes[c] <= '0;
        r_total_beats[c] <= '0;
        r_pkt_count[c]   <= '0;
        r_active[c]      <= '0;
        r_acc[c]         <= '0;
        r_win_bytes[c]   <= '0;
      end
    end else begin
      r_timer     <= w_last_cyc ? '0 : r_timer + TW'(1);
      r_win_valid <= w_last_cyc;
      for (int c = 0; c < NUM_CH; c++) begin
        r_total_bytes[c] <= sat_cnt(r_total_bytes[c], w_bytes[c]);
        r_total_beats[c] <= sat_cnt(r_total_beats[c], BW'(w_hs[c]));
        r_pkt_count[c]   <= sat_cnt(r_pkt_count[c], BW'(w_hs[c] & mon_tlast[c]));
        r_active[c]      <= sat_cnt(r_active[c], BW'(r_started[c]));
        if (w_hs[c]) r_started[c] <= 1'b1;
        if (w_keep_bad[c]) r_keep_err[c] <= 1'b1;
        if (w_last_cyc) begin
          r_win_bytes[c] <= sat_win(r_acc[c], w_bytes[c]);
          r_acc[c]       <= '0;
        end else begin
          r_acc[c] <= sat_win(r_acc[c], w_bytes[c]);
        end
      end
    end
  end

  always_comb begin
    total_bytes   = '0;
    total_beats   = '0;
    pkt_count     = '0;
    active_cycles = '0;
    window_bytes  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      total_bytes[c*CNT_WIDTH +: CNT_WIDTH]   = r_total_bytes[c];
      total_beats[c*CNT_WIDTH +: CNT_WIDTH]   = r_total_beats[c];
      pkt_count[c*CNT_WIDTH +: CNT_WIDTH]     = r_pkt_count[c];
      active_cycles[c*CNT_WIDTH +: CNT_WIDTH] = r_active[c];
      window_bytes[c*WIN_WIDTH +: WIN_WIDTH]  = r_win_bytes[c];
    end
  end

  assign window_valid = r_win_valid;
  assign keep_err     = r_keep_err;

endmodule

// File: tb/tb_axis_rate_monitor.sv
// Directed bench for axis_rate_monitor: main instance (48-bit counters, 16-cycle window) and a
// second instance with 8-bit counters sharing the same stimulus for saturation.
module tb_axis_rate_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [1:0]  tvalid;
  logic [1:0]  tready;
  logic [15:0] tkeep;
  logic [1:0]  tlast;

  logic [95:0] total_bytes, total_beats, pkt_count, active_cycles;
  logic [63:0] window_bytes;
  logic        window_valid;
  logic [1:0]  keep_err;

  logic [15:0] s_total_bytes, s_total_beats, s_pkt_count, s_active_cycles;
  logic [63:0] s_window_bytes;
  logic        s_window_valid;
  logic [1:0]  s_keep_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_rate_monitor #(
    .DATA_WIDTH(64), .NUM_CH(2), .WINDOW_CYCLES(16), .CNT_WIDTH(48), .WIN_WIDTH(32)
  ) dut (
    .s_aclk(clk), .s_areset(rst), .clear(clear),
    .mon_tvalid(tvalid), .mon_tready(tready), .mon_tkeep(tkeep), .mon_tlast(tlast),
    .total_bytes(total_bytes), .total_beats(total_beats), .pkt_count(pkt_count),
    .active_cycles(active_cycles), .window_bytes(window_bytes),
    .window_valid(window_valid), .keep_err(keep_err)
  );

  axis_rate_monitor #(
    .DATA_WIDTH(64), .NUM_CH(2), .WINDOW_CYCLES(16), .CNT_WIDTH(8), .WIN_WIDTH(32)
  ) dut_sat (
    .s_aclk(clk), .s_areset(rst), .clear(clear),
    .mon_tvalid(tvalid), .mon_tready(tready), .mon_tkeep(tkeep), .mon_tlast(tlast),
    .total_bytes(s_total_bytes), .total_beats(s_total_beats), .pkt_count(s_pkt_count),
    .active_cycles(s_active_cycles), .window_bytes(s_window_bytes),
    .window_valid(s_window_valid), .keep_err(s_keep_err)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // After this returns, the current cycle has window timer count 0.
  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic idle();
    tvalid = 2'b00;
    tready = 2'b00;
    tkeep  = 16'h0;
    tlast  = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear = 1'b0;
    idle();
    repeat (3) tick();
    checks++;
    if ((total_bytes | total_beats | pkt_count | active_cycles) !== 96'h0) begin
      errors++;
      $display("FAIL reset_counters: got %h expected 0", total_bytes | total_beats);
    end
    checks++;
    if ({window_valid, keep_err, window_bytes} !== 67'h0) begin
      errors++;
      $display("FAIL reset_window: got valid=%b err=%b wb=%h expected 0",
               window_valid, keep_err, window_bytes);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (window_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_valid: got %b expected 0", window_valid);
    end
  endtask

  task automatic test_basic();
    do_clear();
    tready = 2'b11;
    for (int i = 0; i < 10; i++) begin
      tvalid = 2'b01;
      tkeep  = (i == 9) ? 16'h000F : 16'h00FF;
      tlast  = (i == 9) ? 2'b01 : 2'b00;
      tick();
    end
    idle();
    checks++;
    if (total_bytes[47:0] !== 48'd76) begin
      errors++;
      $display("FAIL basic_bytes: got %0d expected 76", total_bytes[47:0]);
    end
    checks++;
    if (total_beats[47:0] !== 48'd10) begin
      errors++;
      $display("FAIL basic_beats: got %0d expected 10", total_beats[47:0]);
    end
    checks++;
    if (pkt_count[47:0] !== 48'd1) begin
      errors++;
      $display("FAIL basic_pkts: got %0d expected 1", pkt_count[47:0]);
    end
    checks++;
    if (active_cycles[47:0] !== 48'd9) begin
      errors++;
      $display("FAIL basic_active: got %0d expected 9", active_cycles[47:0]);
    end
    checks++;
    if (keep_err !== 2'b00) begin
      errors++;
      $display("FAIL basic_keep_err: got %b expected 00", keep_err);
    end
    checks++;
    if ({total_bytes[95:48], total_beats[95:48], pkt_count[95:48], active_cycles[95:48]} !==
        192'h0) begin
      errors++;
      $display("FAIL basic_ch1_idle: got bytes=%0d beats=%0d expected 0",
               total_bytes[95:48], total_beats[95:48]);
    end
  endtask

  task automatic test_tready_toggle();
    do_clear();
    for (int i = 0; i < 10; i++) begin
      tvalid = 2'b01;
      tkeep  = 16'h00FF;
      tready = {1'b0, i[0]};
      tick();
    end
    idle();
    checks++;
    if (total_beats[47:0] !== 48'd5) begin
      errors++;
      $display("FAIL toggle_beats: got %0d expected 5", total_beats[47:0]);
    end
    checks++;
    if (total_bytes[47:0] !== 48'd40) begin
      errors++;
      $display("FAIL toggle_bytes: got %0d expected 40", total_bytes[47:0]);
    end
  endtask

  task automatic test_window();
    do_clear();
    tvalid = 2'b01;
    tready = 2'b11;
    tkeep  = 16'h00FF;
    for (int n = 1; n <= 40; n++) begin
      tick();
      checks++;
      if (window_valid !== (n == 16 || n == 32)) begin
        errors++;
        $display("FAIL window_pulse_%0d: got %b expected %b", n, window_valid,
                 (n == 16 || n == 32));
      end
      if (n == 16 || n == 24 || n == 32) begin
        checks++;
        if (window_bytes !== {32'd0, 32'd128}) begin
          errors++;
          $display("FAIL window_bytes_%0d: got %h expected %h", n, window_bytes,
                   {32'd0, 32'd128});
        end
      end
    end
    idle();
    // Single beats on count 15 (closing window) and count 0 (new window).
    do_clear();
    tready = 2'b11;
    for (int n = 0; n < 32; n++) begin
      tvalid = (n == 15 || n == 16) ? 2'b01 : 2'b00;
      tkeep  = (n == 15) ? 16'h000F : 16'h0003;
      tick();
      if (n == 15) begin
        checks++;
        if (window_valid !== 1'b1 || window_bytes[31:0] !== 32'd4) begin
          errors++;
          $display("FAIL window_boundary_close: got valid=%b bytes=%0d expected 1/4",
                   window_valid, window_bytes[31:0]);
        end
      end
      if (n == 31) begin
        checks++;
        if (window_valid !== 1'b1 || window_bytes[31:0] !== 32'd2) begin
          errors++;
          $display("FAIL window_boundary_open: got valid=%b bytes=%0d expected 1/2",
                   window_valid, window_bytes[31:0]);
        end
      end
    end
    idle();
  endtask

  task automatic test_keep_err();
    do_clear();
    tready = 2'b11;
    tvalid = 2'b01;
    tkeep  = 16'h00A5;
    tick();
    checks++;
    if (keep_err !== 2'b01 || total_bytes[47:0] !== 48'd4) begin
      errors++;
      $display("FAIL keep_a5: got err=%b bytes=%0d expected 01/4", keep_err, total_bytes[47:0]);
    end
    tkeep = 16'h0000;
    tick();
    checks++;
    if (total_bytes[47:0] !== 48'd4 || total_beats[47:0] !== 48'd2) begin
      errors++;
      $display("FAIL keep_zero: got bytes=%0d beats=%0d expected 4/2",
               total_bytes[47:0], total_beats[47:0]);
    end
    idle();
    repeat (5) tick();
    checks++;
    if (keep_err !== 2'b01) begin
      errors++;
      $display("FAIL keep_sticky: got %b expected 01", keep_err);
    end
    do_clear();
    checks++;
    if (keep_err !== 2'b00) begin
      errors++;
      $display("FAIL keep_cleared: got %b expected 00", keep_err);
    end
  endtask

  task automatic test_saturation();
    do_clear();
    tready = 2'b11;
    tvalid = 2'b01;
    tkeep  = 16'h00FF;
    repeat (40) tick();
    idle();
    checks++;
    if (s_total_bytes[7:0] !== 8'd255) begin
      errors++;
      $display("FAIL sat_bytes: got %0d expected 255", s_total_bytes[7:0]);
    end
    checks++;
    if (s_total_beats[7:0] !== 8'd40) begin
      errors++;
      $display("FAIL sat_beats: got %0d expected 40", s_total_beats[7:0]);
    end
    checks++;
    if (total_bytes[47:0] !== 48'd320) begin
      errors++;
      $display("FAIL wide_bytes: got %0d expected 320", total_bytes[47:0]);
    end
  endtask

  // Runs straight after saturation, so counters and window_bytes are nonzero mid-window.
  task automatic test_clear();
    tready = 2'b11;
    tvalid = 2'b10;
    tkeep  = 16'hFF00;
    clear  = 1'b1;
    tick();
    clear = 1'b0;
    idle();
    checks++;
    if ((total_bytes | total_beats | pkt_count | active_cycles) !== 96'h0) begin
      errors++;
      $display("FAIL clear_counters: got bytes=%h beats=%h expected 0", total_bytes, total_beats);
    end
    checks++;
    if ({window_valid, keep_err, window_bytes} !== 67'h0) begin
      errors++;
      $display("FAIL clear_window: got valid=%b wb=%h expected 0", window_valid, window_bytes);
    end
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (n >= 15) begin
        checks++;
        if (window_valid !== (n == 16)) begin
          errors++;
          $display("FAIL clear_restart_%0d: got %b expected %b", n, window_valid, (n == 16));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    tready = 2'b11;
    tvalid = 2'b01;
    tkeep  = 16'h00FF;
    repeat (5) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (total_bytes !== 96'h0 || total_beats !== 96'h0) begin
      errors++;
      $display("FAIL async_reset: got bytes=%h beats=%h expected 0", total_bytes, total_beats);
    end
    idle();
    repeat (2) tick();
    rst = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (n >= 15) begin
        checks++;
        if (window_valid !== (n == 16)) begin
          errors++;
          $display("FAIL reset_restart_%0d: got %b expected %b", n, window_valid, (n == 16));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tready_toggle();
    test_window();
    test_keep_err();
    test_saturation();
    test_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
